status_serial_rx: RTL and testbench

//  Keypad-side receiver for the alarm status link driven by the main module's serial status transmitter.

---
 rtl/status_serial_rx_pkg.sv | 21 ++
 rtl/serial_shift_in.sv | 53 +++++
 rtl/status_serial_rx.sv | 159 +++++++++++++++
 tb/tb_status_serial_rx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/status_serial_rx_pkg.sv
// Shared definitions for the alarm status link (receiver and transmitter side):
// status-word field positions, default frame width and receiver FSM encodings.
package status_serial_rx_pkg;

    // Status word field bit indices
    localparam int unsigned ST_ARMED = 3;
    localparam int unsigned ST_ALARM = 2;
    localparam int unsigned ST_S1    = 1;
    localparam int unsigned ST_S2    = 0;

    // Default payload width and link watchdog limit
    localparam int unsigned MSG_W_DEF    = 4;
    localparam int unsigned WDOG_MAX_DEF = 16;

    // Receiver FSM encodings
    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/serial_shift_in.sv
// MSG_W-bit MSB-first shift register with a saturating bit counter.
// load_i restarts a frame with the current bit, shift_i appends the current bit.
module serial_shift_in #(
    parameter int unsigned MSG_W = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [MSG_W-1:0] data_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MSG_W);

    logic [MSG_W-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next shift contents and bit count; load wins over shift
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            data_d = {{(MSG_W-1){1'b0}}, bit_i};
            cnt_d  = CNT_W'(1);
        end else if (shift_i) begin
            data_d = {data_q[MSG_W-2:0], bit_i};
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Shift register and counter state
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the shift register is plain flops, not a memory, so it is reset along with the counter.
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o = data_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/status_serial_rx.sv
// Keypad-side receiver for the alarm serial status link. Deserialises
// STATUS_SEND/STATUS_OUT frames into the registered status word
// {ARMED, ALARM, SENSOR1, SENSOR2}, rejects ALARM-without-ARMED frames and
// truncated frames, and reports link health on LINK_OK.
// Optional feature: define LINK_WATCHDOG_EN to drop LINK_OK and force the
// fail-safe status 4'b0100 after WDOG_MAX cycles without a valid frame.
module status_serial_rx
    import status_serial_rx_pkg::*;
#(
    parameter int unsigned MSG_W = MSG_W_DEF
`ifdef LINK_WATCHDOG_EN
    ,
    parameter int unsigned WDOG_MAX = WDOG_MAX_DEF
`endif
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             STATUS_SEND,
    input  logic             STATUS_OUT,
    output logic [MSG_W-1:0] STATUS,
    output logic             FRAME_VALID,
    output logic             FRAME_ERR,
    output logic             LINK_OK
);

    localparam int unsigned      CNT_W    = $clog2(MSG_W) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MSG_W);

    rx_state_e        state_q, state_d;
    logic [MSG_W-1:0] status_q, status_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             link_ok_q, link_ok_d;

    logic             sr_load, sr_shift;
    logic [MSG_W-1:0] sr_data;
    logic [CNT_W-1:0] sr_cnt;
    logic             frame_done;
    logic             frame_legal;

    serial_shift_in #(
        .MSG_W (MSG_W),
        .CNT_W (CNT_W)
    ) u_shift_in (
        .clk     (CLK),
        .rst_n   (RST_N),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .bit_i   (STATUS_OUT),
        .data_o  (sr_data),
        .cnt_o   (sr_cnt)
    );

    // A full frame sits in the shift register for one cycle before it is judged
    assign frame_done  = (state_q == RX_SHIFT) && (sr_cnt == CNT_FULL);
    // An alarm is only meaningful while the system is armed
    assign frame_legal = !(sr_data[ST_ALARM] && !sr_data[ST_ARMED]);

`ifdef LINK_WATCHDOG_EN
    localparam int unsigned      WD_W     = $clog2(WDOG_MAX + 1);
    localparam logic [WD_W-1:0]  WD_FULL  = WD_W'(WDOG_MAX);
    localparam logic [MSG_W-1:0] FAILSAFE = MSG_W'(1) << ST_ALARM;

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

    // Receive FSM: next state, shift control, status update and pulses
    always_comb begin
        state_d       = state_q;
        status_d      = status_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        link_ok_d     = link_ok_q;
        sr_load       = 1'b0;
        sr_shift      = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (STATUS_SEND) begin
                    sr_load = 1'b1;
                    state_d = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (frame_done) begin
                    // The finished frame is judged first; a coincident start begins the next one
                    if (frame_legal) begin
                        status_d      = sr_data;
                        frame_valid_d = 1'b1;
                        link_ok_d     = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    if (STATUS_SEND) begin
                        sr_load = 1'b1;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else if (STATUS_SEND) begin
                    // Truncated frame: drop it and restart on the new start bit
                    frame_err_d = 1'b1;
                    sr_load     = 1'b1;
                end else begin
                    sr_shift = 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase

`ifdef LINK_WATCHDOG_EN
        if (frame_valid_d) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != WD_FULL) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end else begin
            wd_cnt_d = wd_cnt_q;
        end
        // Silent link: show alarm and report link loss until a valid frame arrives
        if (!frame_valid_d && (wd_cnt_d == WD_FULL)) begin
            status_d  = FAILSAFE;
            link_ok_d = 1'b0;
        end
`endif
    end

    // FSM state and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= RX_IDLE;
            status_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            link_ok_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            status_q      <= status_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            link_ok_q     <= link_ok_d;
        end
    end

`ifdef LINK_WATCHDOG_EN
    // Link watchdog counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`endif

    assign STATUS      = status_q;
    assign FRAME_VALID = frame_valid_q;
    assign FRAME_ERR   = frame_err_q;
    assign LINK_OK     = link_ok_q;

endmodule

// File: tb/tb_status_serial_rx.sv
// Directed bench for status_serial_rx: valid, illegal, truncated,
// back-to-back and reset-interrupted frames (plus the link watchdog when
// LINK_WATCHDOG_EN is defined). Inputs change 1 time unit after each rising
// edge; outputs are checked at that same point.
module tb_status_serial_rx;

    logic       clk;
    logic       rst_n;
    logic       status_send;
    logic       status_out;
    logic [3:0] status;
    logic       frame_valid;
    logic       frame_err;
    logic       link_ok;

    int checks = 0;
    int errors = 0;

    status_serial_rx dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .STATUS_SEND (status_send),
        .STATUS_OUT  (status_out),
        .STATUS      (status),
        .FRAME_VALID (frame_valid),
        .FRAME_ERR   (frame_err),
        .LINK_OK     (link_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its hand-computed expectation
    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one serial cycle, then move to 1 unit after the sampling edge
    task automatic step(input logic send, input logic data);
        status_send = send;
        status_out  = data;
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst_n       = 1'b0;
        status_send = 1'b0;
        status_out  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_status", status, 4'b0000);
        check("reset_valid", {3'b0, frame_valid}, 4'd0);
        check("reset_err", {3'b0, frame_err}, 4'd0);
        check("reset_link", {3'b0, link_ok}, 4'd0);
        rst_n = 1'b1;
        step(1'b0, 1'b0);

        // 1: frame 1,0,1,0 then 3 standby cycles
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("t1_no_early_valid", {3'b0, frame_valid}, 4'd0);
        check("t1_status_before", status, 4'b0000);
        step(1'b0, 1'b0);
        check("t1_status", status, 4'b1010);
        check("t1_valid", {3'b0, frame_valid}, 4'd1);
        check("t1_err", {3'b0, frame_err}, 4'd0);
        check("t1_link", {3'b0, link_ok}, 4'd1);
        step(1'b0, 1'b0);
        check("t1_valid_pulse_end", {3'b0, frame_valid}, 4'd0);
        step(1'b0, 1'b0);

        // 2: illegal frame 0,1,0,0 (ALARM without ARMED)
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("t2_err", {3'b0, frame_err}, 4'd1);
        check("t2_no_valid", {3'b0, frame_valid}, 4'd0);
        check("t2_status_held", status, 4'b1010);
        step(1'b0, 1'b0);
        check("t2_err_pulse_end", {3'b0, frame_err}, 4'd0);

        // 3: truncated frame restarted at its second bit, then 1,1,0,0
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("t3_restart_err", {3'b0, frame_err}, 4'd1);
        check("t3_restart_no_valid", {3'b0, frame_valid}, 4'd0);
        step(1'b0, 1'b1);
        check("t3_err_pulse_end", {3'b0, frame_err}, 4'd0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("t3_no_early_valid", {3'b0, frame_valid}, 4'd0);
        step(1'b0, 1'b0);
        check("t3_status", status, 4'b1100);
        check("t3_valid", {3'b0, frame_valid}, 4'd1);
        check("t3_no_err", {3'b0, frame_err}, 4'd0);
        step(1'b0, 1'b0);
        check("t3_single_valid", {3'b0, frame_valid}, 4'd0);

        // 4: back-to-back frames 1,0,0,1 and 1,0,1,1
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("t4_a_status", status, 4'b1001);
        check("t4_a_valid", {3'b0, frame_valid}, 4'd1);
        check("t4_a_no_err", {3'b0, frame_err}, 4'd0);
        step(1'b0, 1'b0);
        check("t4_gap_valid", {3'b0, frame_valid}, 4'd0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("t4_b_no_err", {3'b0, frame_err}, 4'd0);
        step(1'b0, 1'b0);
        check("t4_b_status", status, 4'b1011);
        check("t4_b_valid", {3'b0, frame_valid}, 4'd1);
        check("t4_b_no_err_end", {3'b0, frame_err}, 4'd0);
        step(1'b0, 1'b0);

        // 5: reset for one cycle in the middle of a frame
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_status", status, 4'b0000);
        check("t5_rst_valid", {3'b0, frame_valid}, 4'd0);
        check("t5_rst_err", {3'b0, frame_err}, 4'd0);
        check("t5_rst_link", {3'b0, link_ok}, 4'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("t5_no_pulse_valid", {3'b0, frame_valid}, 4'd0);
        check("t5_no_pulse_err", {3'b0, frame_err}, 4'd0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("t5_status", status, 4'b0011);
        check("t5_valid", {3'b0, frame_valid}, 4'd1);
        check("t5_link", {3'b0, link_ok}, 4'd1);

`ifdef LINK_WATCHDOG_EN
        // 6: silence on the link until the watchdog expires
        repeat (15) step(1'b0, 1'b0);
        check("t6_link_before_expiry", {3'b0, link_ok}, 4'd1);
        check("t6_status_before_expiry", status, 4'b0011);
        step(1'b0, 1'b0);
        check("t6_link_lost", {3'b0, link_ok}, 4'd0);
        check("t6_failsafe_status", status, 4'b0100);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("t6_still_failsafe", status, 4'b0100);
        step(1'b0, 1'b0);
        check("t6_restored_status", status, 4'b1000);
        check("t6_restored_link", {3'b0, link_ok}, 4'd1);
`else
        // Without the watchdog the last status and link state hold indefinitely
        repeat (20) step(1'b0, 1'b0);
        check("hold_link", {3'b0, link_ok}, 4'd1);
        check("hold_status", status, 4'b0011);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
